// File: rtl/tmds_pll_sequencer.sv
// -----------------------------------------------------------------------------
// tmds_pll_sequencer
//
// Power-up and lock-supervision controller for the HDMI TMDS serial-clock PLL.
// Holds the PLL in reset, waits for lock and qualifies it as stable before it
// releases the downstream video/serializer reset. While running it watches for
// lock loss, re-sequences the PLL when lock is lost, and keeps fault status.
// Everything runs in the 27 MHz crystal domain.
//
// Ports
//   clkin        in   27 MHz crystal clock, rising edge
//   reset        in   asynchronous active-high reset
//   pll_lock     in   raw PLL LOCK, asynchronous to clkin
//   restart      in   single-cycle request to re-sequence the PLL
//   pll_reset    out  PLL RESET, active-high
//   rst_out      out  downstream reset, active-high, registered
//   ready        out  high only in RUN, registered
//   state        out  FSM state (0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN)
//   timeout_err  out  sticky: at least one lock timeout since reset/restart
//   relock_count out  lock-loss events seen in RUN, saturating
// -----------------------------------------------------------------------------
module tmds_pll_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 2700,
  parameter int LOSS_FILTER   = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             restart,
  output logic             pll_reset,
  output logic             rst_out,
  output logic             ready,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] relock_count
);

  // The shared counter only ever has to hold terminal-count values up to
  // the largest of the three intervals minus one.
  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int LW    = (LOSS_FILTER > 0) ? $clog2(LOSS_FILTER + 1) : 1;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [LW-1:0]    loss_q;
  logic [LW-1:0]    loss_d;
  logic             sync1_q;
  logic             lock_s_q;
  logic             pll_reset_q;
  logic             rst_out_q;
  logic             ready_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] relock_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Lock synchronizer: two flops into the crystal domain
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  assign loss_d = loss_q + LW'(1);

  // Sequencer FSM with registered outputs
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      loss_q        <= '0;
      pll_reset_q   <= 1'b1;
      rst_out_q     <= 1'b1;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      relock_q      <= '0;
    end else if (restart) begin
      // Restart overrides any timeout or loss event on the same edge, so
      // neither timeout_err nor relock_count can be updated here.
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      loss_q        <= '0;
      pll_reset_q   <= 1'b1;
      rst_out_q     <= 1'b1;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_q       <= RESET_PLL;
            cnt_q         <= '0;
            pll_reset_q   <= 1'b1;
            timeout_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STABLE: begin
          if (!lock_s_q) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            loss_q    <= '0;
            rst_out_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (lock_s_q) begin
            loss_q <= '0;
          end else if (loss_d == LW'(LOSS_FILTER)) begin
            // Qualified lock loss: downstream goes back into reset on the
            // same edge that the PLL reset is reasserted.
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            ready_q     <= 1'b0;
            relock_q    <= sat_inc(relock_q);
          end else begin
            loss_q <= loss_d;
          end
        end
        default: begin
          state_q     <= RESET_PLL;
          cnt_q       <= '0;
          loss_q      <= '0;
          pll_reset_q <= 1'b1;
          rst_out_q   <= 1'b1;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset    = pll_reset_q;
  assign rst_out      = rst_out_q;
  assign ready        = ready_q;
  assign state        = state_q;
  assign timeout_err  = timeout_err_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_tmds_pll_sequencer.sv
module tb_tmds_pll_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       rst_out;
  logic       ready;
  logic [1:0] state;
  logic       timeout_err;
  logic [7:0] relock_count;

  // Narrow-counter instance sharing the same stimulus, for saturation
  logic       pll_reset2;
  logic       rst_out2;
  logic       ready2;
  logic [1:0] state2;
  logic       timeout_err2;
  logic [1:0] relock_count2;

  int compared;
  int mismatched;

  tmds_pll_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .LOSS_FILTER(3), .CNT_W(8)
  ) dut (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock), .restart(restart),
    .pll_reset(pll_reset), .rst_out(rst_out), .ready(ready), .state(state),
    .timeout_err(timeout_err), .relock_count(relock_count)
  );

  tmds_pll_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .LOSS_FILTER(3), .CNT_W(2)
  ) dut2 (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock), .restart(restart),
    .pll_reset(pll_reset2), .rst_out(rst_out2), .ready(ready2), .state(state2),
    .timeout_err(timeout_err2), .relock_count(relock_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] want, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== want && n < budget) begin
      tick();
      n++;
    end
    compared++;
    if (state !== want) begin
      mismatched++;
      $display("FAIL %s wait_state got=%0d want=%0d after %0d cycles", tag, state, want, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_lock = 1'b1; restart = 1'b0;
    tick(); tick();
    compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL reset_state got=%0d want=0", state); end
    compared++; if (pll_reset !== 1'b1) begin mismatched++; $display("FAIL reset_pll_reset got=%0b want=1", pll_reset); end
    compared++; if (rst_out !== 1'b1) begin mismatched++; $display("FAIL reset_rst_out got=%0b want=1", rst_out); end
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got=%0b want=0", ready); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL reset_timeout_err got=%0b want=0", timeout_err); end
    compared++; if (relock_count !== 8'd0) begin mismatched++; $display("FAIL reset_relock got=%0d want=0", relock_count); end
  endtask

  // Release at edge 0: RESET_PLL edges 1..3, WAIT_LOCK at 4, STABLE 5..12, RUN at 13
  task automatic test_bringup();
    logic [1:0] es;
    reset = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      tick();
      es = (n <= 3) ? 2'd0 : (n == 4) ? 2'd1 : (n <= 12) ? 2'd2 : 2'd3;
      compared++; if (state !== es) begin mismatched++; $display("FAIL bringup_state n=%0d got=%0d want=%0d", n, state, es); end
      compared++; if (pll_reset !== (n <= 3)) begin mismatched++; $display("FAIL bringup_pll_reset n=%0d got=%0b want=%0b", n, pll_reset, (n <= 3)); end
      compared++; if (rst_out !== (n < 13)) begin mismatched++; $display("FAIL bringup_rst_out n=%0d got=%0b want=%0b", n, rst_out, (n < 13)); end
      compared++; if (ready !== (n == 13)) begin mismatched++; $display("FAIL bringup_ready n=%0d got=%0b want=%0b", n, ready, (n == 13)); end
    end
  endtask

  // Lock never arrives: pll_reset high 4 cycles out of every 24
  task automatic test_timeout();
    logic epr;
    reset = 1'b1; pll_lock = 1'b0;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      epr = ((n % 24) < 4);
      compared++; if (pll_reset !== epr) begin mismatched++; $display("FAIL timeout_pll_reset n=%0d got=%0b want=%0b", n, pll_reset, epr); end
      compared++; if (state !== (epr ? 2'd0 : 2'd1)) begin mismatched++; $display("FAIL timeout_state n=%0d got=%0d want=%0d", n, state, (epr ? 0 : 1)); end
      compared++; if (timeout_err !== (n >= 24)) begin mismatched++; $display("FAIL timeout_err n=%0d got=%0b want=%0b", n, timeout_err, (n >= 24)); end
      compared++; if (rst_out !== 1'b1 || ready !== 1'b0) begin mismatched++; $display("FAIL timeout_outs n=%0d rst_out=%0b ready=%0b want 1/0", n, rst_out, ready); end
    end
  endtask

  // One-cycle lock drop while in STABLE: back to WAIT_LOCK, then a full STABLE count
  task automatic test_unstable();
    logic [1:0] es;
    reset = 1'b1; pll_lock = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      es = (n <= 3) ? 2'd0 : (n == 4) ? 2'd1 : (n <= 10) ? 2'd2 :
           (n == 11) ? 2'd1 : (n <= 19) ? 2'd2 : 2'd3;
      compared++; if (state !== es) begin mismatched++; $display("FAIL unstable_state n=%0d got=%0d want=%0d", n, state, es); end
      compared++; if (rst_out !== (n < 20)) begin mismatched++; $display("FAIL unstable_rst_out n=%0d got=%0b want=%0b", n, rst_out, (n < 20)); end
      if (n == 8) pll_lock = 1'b0;
      if (n == 9) pll_lock = 1'b1;
    end
  endtask

  task automatic test_loss_filter();
    logic [1:0] es;
    // 2-cycle dropout is filtered out
    pll_lock = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      compared++; if (state !== 2'd3 || rst_out !== 1'b0) begin mismatched++; $display("FAIL loss2_run k=%0d state=%0d rst_out=%0b want 3/0", k, state, rst_out); end
      if (k == 2) pll_lock = 1'b1;
    end
    compared++; if (relock_count !== 8'd0) begin mismatched++; $display("FAIL loss2_relock got=%0d want=0", relock_count); end
    // 3-cycle dropout qualifies; automatic re-sequence back to RUN
    pll_lock = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      es = (k <= 4) ? 2'd3 : (k <= 8) ? 2'd0 : (k == 9) ? 2'd1 : (k <= 17) ? 2'd2 : 2'd3;
      compared++; if (state !== es) begin mismatched++; $display("FAIL loss3_state k=%0d got=%0d want=%0d", k, state, es); end
      compared++; if (rst_out !== (es != 2'd3) || ready !== (es == 2'd3)) begin mismatched++; $display("FAIL loss3_outs k=%0d rst_out=%0b ready=%0b", k, rst_out, ready); end
      if (k == 5) begin
        compared++; if (relock_count !== 8'd1) begin mismatched++; $display("FAIL loss3_relock got=%0d want=1", relock_count); end
      end
      if (k == 3) pll_lock = 1'b1;
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2;
    reset = 1'b1; pll_lock = 1'b1;
    tick();
    reset = 1'b0;
    repeat (13) tick();
    for (int ev = 1; ev <= 5; ev++) begin
      pll_lock = 1'b0;
      for (int k = 1; k <= 18; k++) begin
        tick();
        if (k == 3) pll_lock = 1'b1;
      end
      exp2 = (ev >= 3) ? 2'd3 : 2'(ev);
      compared++; if (relock_count !== 8'(ev)) begin mismatched++; $display("FAIL sat_relock8 ev=%0d got=%0d want=%0d", ev, relock_count, ev); end
      compared++; if (relock_count2 !== exp2) begin mismatched++; $display("FAIL sat_relock2 ev=%0d got=%0d want=%0d", ev, relock_count2, exp2); end
      compared++; if (state !== 2'd3) begin mismatched++; $display("FAIL sat_state ev=%0d got=%0d want=3", ev, state); end
    end
  endtask

  task automatic test_restart();
    int n;
    // Lose lock in RUN and keep it lost until a timeout is recorded
    pll_lock = 1'b0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 60) begin tick(); n++; end
    compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL restart_setup_timeout got=%0b want=1", timeout_err); end
    pll_lock = 1'b1;
    wait_state(2'd3, 40, "restart_run");
    compared++; if (relock_count !== 8'd6 || timeout_err !== 1'b1) begin mismatched++; $display("FAIL restart_pre relock=%0d err=%0b want 6/1", relock_count, timeout_err); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL restart_state got=%0d want=0", state); end
    compared++; if (rst_out !== 1'b1 || ready !== 1'b0 || pll_reset !== 1'b1) begin mismatched++; $display("FAIL restart_outs rst_out=%0b ready=%0b pll_reset=%0b want 1/0/1", rst_out, ready, pll_reset); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL restart_timeout_err got=%0b want=0", timeout_err); end
    compared++; if (relock_count !== 8'd6 || relock_count2 !== 2'd3) begin mismatched++; $display("FAIL restart_relock got=%0d/%0d want=6/3", relock_count, relock_count2); end
  endtask

  // restart coincides with the qualifying loss edge: no relock increment
  task automatic test_restart_priority();
    wait_state(2'd3, 40, "prio_run");
    pll_lock = 1'b0;
    repeat (4) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    pll_lock = 1'b1;
    compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL prio_state got=%0d want=0", state); end
    compared++; if (relock_count !== 8'd6) begin mismatched++; $display("FAIL prio_relock got=%0d want=6", relock_count); end
  endtask

  task automatic test_async_reset();
    wait_state(2'd2, 30, "areset_stable");
    #2;
    reset = 1'b1;
    #1;
    compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL areset_state got=%0d want=0", state); end
    compared++; if (pll_reset !== 1'b1 || rst_out !== 1'b1 || ready !== 1'b0) begin mismatched++; $display("FAIL areset_outs pll_reset=%0b rst_out=%0b ready=%0b want 1/1/0", pll_reset, rst_out, ready); end
    compared++; if (relock_count !== 8'd0 || relock_count2 !== 2'd0 || timeout_err !== 1'b0) begin mismatched++; $display("FAIL areset_status relock=%0d/%0d err=%0b want 0/0/0", relock_count, relock_count2, timeout_err); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    pll_lock   = 1'b1;
    restart    = 1'b0;
    test_reset();
    test_bringup();
    test_timeout();
    test_unstable();
    test_loss_filter();
    test_saturation();
    test_restart();
    test_restart_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tmds_pll_sequencer.md
Name: tmds_pll_sequencer

Overview:
- Power-up and lock-supervision controller for the HDMI TMDS serial-clock PLL (27 MHz crystal in, 371.25 MHz out).
- Drives the PLL RESET pin and holds the downstream video/serializer reset until PLL lock has been stable for a qualified time.
- Detects lock loss in operation, re-sequences the PLL, and reports status and fault counts.
- Runs entirely in the 27 MHz crystal domain, between the PLL instance and the video top-level reset tree.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per PLL reset attempt (min 1).
- LOCK_TIMEOUT, 27000: cycles to wait for lock after PLL reset release before retrying (1 ms at 27 MHz).
- STABLE_CYCLES, 2700: consecutive locked cycles required before releasing downstream reset (100 us).
- LOSS_FILTER, 4: consecutive unlocked cycles in RUN that count as lock loss (glitch filter, min 1).
- CNT_W, 8: width of relock_count.

Ports:
- clkin  input  1  27 MHz crystal clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pll_lock  input  1  raw PLL LOCK, asynchronous to clkin.
- restart  input  1  synchronous single-cycle request to re-sequence the PLL.
- pll_reset  output  1  to PLL RESET, active-high.
- rst_out  output  1  downstream reset, active-high, registered.
- ready  output  1  high only in RUN, registered.
- state  output  2  current FSM state encoding.
- timeout_err  output  1  sticky flag: at least one lock timeout occurred.
- relock_count  output  CNT_W  lock-loss events seen in RUN, saturating.

Behaviour:
- Reset values:
  - state = RESET_PLL (0).
  - pll_reset = 1, rst_out = 1, ready = 0.
  - timeout_err = 0, relock_count = 0.
  - Internal counter and loss counter = 0; synchronizer flops = 0.
- pll_lock passes through a 2-flop synchronizer to lock_s. A lock edge reaches the FSM 2 cycles late; lock_s is the only lock signal the FSM uses.
- One shared cycle counter is sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It clears on every state entry.
- States: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3.
- RESET_PLL:
  - pll_reset = 1, rst_out = 1.
  - When the counter reaches RST_CYCLES-1, go to WAIT_LOCK. pll_reset is therefore high for exactly RST_CYCLES cycles per attempt, counted from reset release or state entry.
- WAIT_LOCK:
  - pll_reset = 0, rst_out = 1.
  - If lock_s = 1, go to STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1, go to RESET_PLL and set timeout_err.
- STABLE:
  - pll_reset = 0, rst_out = 1.
  - If lock_s = 0, go to WAIT_LOCK with a fresh timeout.
  - When the counter reaches STABLE_CYCLES-1 with lock_s = 1, go to RUN.
  - rst_out falls and ready rises on the same edge that enters RUN.
- RUN:
  - pll_reset = 0, rst_out = 0, ready = 1.
  - The loss counter increments on each cycle with lock_s = 0 and clears when lock_s = 1.
  - When it reaches LOSS_FILTER, go to RESET_PLL. On that same edge rst_out rises, ready falls, and relock_count increments unless it is all ones.
  - Lock dropouts shorter than LOSS_FILTER cycles have no effect.
- restart:
  - Highest priority in every state. On the next edge the FSM goes to RESET_PLL, counters clear, rst_out = 1, ready = 0, and timeout_err clears.
  - relock_count is not changed.
  - restart on the same edge as a timeout or loss event: restart wins, timeout_err ends at 0, relock_count does not increment.
- ready and rst_out are never both 1. rst_out never glitches low outside RUN.
- Retry after timeout is unlimited; timeout_err stays set until restart or reset.
- reset asserted mid-operation returns everything to reset values immediately (asynchronous). Release is synchronous to clkin through normal flop behaviour; no extra reset synchronizer lives in this block.

Test Plan:
- Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_FILTER=3.
- Nominal bring-up:
  - Stimulus: pll_lock held 1 from time 0.
  - Response: pll_reset high exactly 4 cycles; WAIT_LOCK then STABLE within 3 cycles; RUN after 8 STABLE cycles; rst_out 1->0 and ready 0->1 on the same edge; state=3.
- Lock timeout:
  - Stimulus: pll_lock held 0.
  - Response: pll_reset pulses 4 cycles every 24 cycles; timeout_err=1 after the first 20-cycle wait; rst_out stays 1; ready stays 0.
- Unstable lock:
  - Stimulus: pll_lock drops for 1 cycle at STABLE cycle 5.
  - Response: state returns to 1, then STABLE restarts a full 8-cycle count; rst_out stays 1 throughout.
- Loss filter in RUN:
  - Stimulus: a 2-cycle pll_lock dropout.
  - Response: no change; rst_out=0, relock_count=0.
  - Stimulus: a 3-cycle dropout.
  - Response: RESET_PLL entered; rst_out=1 on that edge; relock_count=1; automatic re-sequence back to RUN.
- Saturation:
  - Stimulus: CNT_W=2, 5 qualifying loss events.
  - Response: relock_count=3.
- Restart and reset mid-operation:
  - Stimulus: restart pulse in RUN with timeout_err=1.
  - Response: next edge state=0, rst_out=1, timeout_err=0, relock_count unchanged.
  - Stimulus: async reset asserted in STABLE.
  - Response: outputs go to reset values without waiting for a clock edge.
